alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Registered decode/issue stage on the producer side of the ALU.
- Accepts one RV32I instruction plus register-file read data per handshake, and decodes the riscv_pkg::alu_op_t operation.
- Selects the A/B operands (register or sign-extended immediate) and the downstream control bits.
- Holds the result in a single-entry pipeline register with a valid/ready handshake toward the execute stage, with stall and flush support.

Parameters:
- WORD_SIZE, 32, datapath width of the operands and store data; immediates sign-extend to WORD_SIZE.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- inst_valid_i  input  1  upstream instruction valid.
- inst_ready_o  output  1  stage can accept an instruction this cycle.
- inst_i  input  32  instruction word.
- rs1_data_i  input  WORD_SIZE  register-file read data for rs1 (inst_i[19:15]).
- rs2_data_i  input  WORD_SIZE  register-file read data for rs2 (inst_i[24:20]).
- flush_i  input  1  discard the held entry (taken branch / exception).
- ex_valid_o  output  1  issued entry valid toward execute.
- ex_ready_i  input  1  execute stage consumes the entry.
- alu_op_o  output  riscv_pkg::alu_op_t  ALU operation (AND, OR, ADD, SUB).
- A_o  output  WORD_SIZE  ALU operand A.
- B_o  output  WORD_SIZE  ALU operand B.
- store_data_o  output  WORD_SIZE  rs2 data for stores.
- rd_o  output  5  destination register index.
- reg_write_o  output  1  write rd with the result.
- mem_read_o  output  1  load.
- mem_write_o  output  1  store.
- branch_o  output  1  conditional branch (BEQ/BNE).
- branch_ne_o  output  1  branch taken when ALU zero_o == 0 (BNE); else taken when zero_o == 1.
- illegal_o  output  1  unsupported encoding.

Behaviour:
- Reset (rst_i high at a clock edge):
  - ex_valid_o=0, alu_op_o=ADD, and all other outputs 0.
  - Reset overrides flush and handshakes.
  - Reset mid-stall drops the held entry.
- inst_ready_o:
  - = !flush_i && (!ex_valid_o || ex_ready_i). It is combinational.
  - Accept occurs when inst_valid_i && inst_ready_o.
- Latency: one cycle. An instruction accepted at edge N appears with ex_valid_o=1 after edge N.
- Stall: while ex_valid_o && !ex_ready_i, all outputs hold their values bit-for-bit and no accept occurs.
- Simultaneous consume and accept (ex_valid_o && ex_ready_i && inst_valid_i): the new entry replaces the old one in the same edge, with no bubble. Full throughput is 1 instr/cycle.
- Consume without accept: ex_valid_o goes to 0 at the next edge. Data fields may hold stale values.
- Flush: flush_i at an edge clears ex_valid_o. No accept that cycle, even if inst_valid_i=1. Flush has priority over ex_ready_i.
- Decode by opcode inst_i[6:0]:
  - 0110011 (R-type), funct7 = inst[31:25]:
    - funct3 000 with funct7 0000000 → ADD.
    - funct3 000 with funct7 0100000 → SUB.
    - funct3 111 with funct7 0000000 → AND.
    - funct3 110 with funct7 0000000 → OR.
    - All other R-type encodings are illegal.
    - For legal R-type: A=rs1, B=rs2, reg_write=1.
  - 0010011 (I-type), immediate = sext(inst[31:20]):
    - funct3 000 → ADD; 111 → AND; 110 → OR; others illegal.
    - A=rs1, B=sext(inst[31:20]), reg_write=1.
  - 0000011 (load): funct3=010 (LW) only.
    - ADD, A=rs1, B=sext(inst[31:20]), mem_read=1, reg_write=1.
  - 0100011 (store): funct3=010 (SW) only.
    - ADD, A=rs1, B=sext({inst[31:25],inst[11:7]}), store_data=rs2, mem_write=1.
  - 1100011 (branch): funct3 000 (BEQ) or 001 (BNE).
    - SUB, A=rs1, B=rs2, branch=1, branch_ne=funct3[0].
  - Any other opcode is illegal.
- Illegal entries:
  - Still handshake through with ex_valid_o=1 and illegal_o=1.
  - alu_op=ADD; reg_write, mem_read, mem_write, branch and branch_ne all forced 0.
- rd_o = inst[11:7] for every entry.
  - reg_write_o is forced 0 when rd=0 (x0 is never written).
  - reg_write_o is forced 0 for store, branch and illegal entries.
- Sign extension replicates the immediate's bit 11 up to WORD_SIZE-1.
- Register data is sampled only at the accept edge. Later changes on rs*_data_i do not affect a held entry.

Test Plan:
- Reset: assert rst_i for 2 cycles with inst_valid_i=1 → ex_valid_o=0, alu_op_o=ADD, all other outputs 0, and inst_ready_o=1 after release.
- R-type throughput: SUB x3,x1,x2 (0x402081B3) with rs1=10, rs2=3, then AND and OR back-to-back with ex_ready_i=1 → one entry per cycle; first entry alu_op=SUB, A=10, B=3, rd=3, reg_write=1.
- Immediate sign extension: ADDI x5,x0,-1 (0xFFF00293) → B_o=0xFFFFFFFF, ADD, reg_write=1. SW x2,-4(x1) (0xFE20AE23) → B_o=0xFFFFFFFC, mem_write=1, reg_write=0, store_data_o=rs2.
- Stall/hold: ex_ready_i=0 for 3 cycles while the upstream presents a new instruction and changes rs*_data_i → inst_ready_o=0, outputs unchanged. On ex_ready_i=1, the new instruction is accepted in that same cycle.
- Flush: flush_i pulse while ex_valid_o=1 and inst_valid_i=1 → ex_valid_o=0 next cycle, instruction not accepted (upstream must re-present it).
- Illegal and x0: opcode 0110111 (LUI) → illegal_o=1 and all control bits 0. ADD x0,x1,x2 → reg_write_o=0, illegal_o=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction into ALU operands and control bits
// and holds the result in a single-entry valid/ready pipeline register toward execute.
package riscv_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;
endpackage

module alu_issue_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inst_valid_i,
  output logic                 inst_ready_o,
  input  logic [31:0]          inst_i,
  input  logic [WORD_SIZE-1:0] rs1_data_i,
  input  logic [WORD_SIZE-1:0] rs2_data_i,
  input  logic                 flush_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output riscv_pkg::alu_op_t   alu_op_o,
  output logic [WORD_SIZE-1:0] A_o,
  output logic [WORD_SIZE-1:0] B_o,
  output logic [WORD_SIZE-1:0] store_data_o,
  output logic [4:0]           rd_o,
  output logic                 reg_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 branch_o,
  output logic                 branch_ne_o,
  output logic                 illegal_o
);
  import riscv_pkg::*;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_t              op;
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [WORD_SIZE-1:0] store_data;
    logic [4:0]           rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic                 branch_ne;
    logic                 illegal;
  } issue_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [WORD_SIZE-1:0] imm_i;
  logic [WORD_SIZE-1:0] imm_s;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign imm_i  = {{(WORD_SIZE-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{(WORD_SIZE-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};

  issue_t dec;
  issue_t entry_d, entry_q;
  logic   valid_d, valid_q;
  logic   accept;

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec    = '0;
    dec.op = ALU_ADD;
    dec.rd = inst_i[11:7];
    unique case (opcode)
      OP_R: begin
        dec.a         = rs1_data_i;
        dec.b         = rs2_data_i;
        dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec.op = ALU_ADD;
          {7'b0100000, 3'b000}: dec.op = ALU_SUB;
          {7'b0000000, 3'b111}: dec.op = ALU_AND;
          {7'b0000000, 3'b110}: dec.op = ALU_OR;
          default:              dec.illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.a         = rs1_data_i;
        dec.b         = imm_i;
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000:  dec.op = ALU_ADD;
          3'b111:  dec.op = ALU_AND;
          3'b110:  dec.op = ALU_OR;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.a         = rs1_data_i;
        dec.b         = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.a          = rs1_data_i;
        dec.b          = imm_s;
        dec.store_data = rs2_data_i;
        dec.mem_write  = 1'b1;
        dec.illegal    = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        dec.op        = ALU_SUB;
        dec.a         = rs1_data_i;
        dec.b         = rs2_data_i;
        dec.branch    = 1'b1;
        dec.branch_ne = funct3[0];
        dec.illegal   = (funct3[2:1] != 2'b00);
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal entries pass through inert; x0 is never a write target.
    if (dec.illegal) begin
      dec            = '0;
      dec.op         = ALU_ADD;
      dec.rd         = inst_i[11:7];
      dec.illegal    = 1'b1;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign inst_ready_o = !flush_i && (!valid_q || ex_ready_i);
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      entry_q    <= '0;
      entry_q.op <= ALU_ADD;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign alu_op_o     = entry_q.op;
  assign A_o          = entry_q.a;
  assign B_o          = entry_q.b;
  assign store_data_o = entry_q.store_data;
  assign rd_o         = entry_q.rd;
  assign reg_write_o  = entry_q.reg_write;
  assign mem_read_o   = entry_q.mem_read;
  assign mem_write_o  = entry_q.mem_write;
  assign branch_o     = entry_q.branch;
  assign branch_ne_o  = entry_q.branch_ne;
  assign illegal_o    = entry_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a cycle-level reference model
// of the decode table and the single-entry handshake rules.
module tb_alu_issue_stage;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, inst_valid_i, flush_i, ex_ready_i;
  logic        inst_ready_o, ex_valid_o;
  logic [31:0] inst_i, rs1_data_i, rs2_data_i;
  alu_op_t     alu_op_o;
  logic [31:0] A_o, B_o, store_data_o;
  logic [4:0]  rd_o;
  logic        reg_write_o, mem_read_o, mem_write_o, branch_o, branch_ne_o, illegal_o;

  always #5 clk_i = ~clk_i;

  alu_issue_stage #(.WORD_SIZE(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .alu_op_o(alu_op_o), .A_o(A_o),
    .B_o(B_o), .store_data_o(store_data_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .branch_ne_o(branch_ne_o), .illegal_o(illegal_o)
  );

  typedef struct packed {
    logic        valid;
    alu_op_t     op;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, bne, ill;
  } out_t;

  out_t obs, exp_o;
  logic exp_known;
  logic ready_obs, ready_exp;
  int   tests_run = 0, tests_failed = 0;

  always_comb begin
    obs = {ex_valid_o, alu_op_o, A_o, B_o, store_data_o, rd_o,
           reg_write_o, mem_read_o, mem_write_o, branch_o, branch_ne_o, illegal_o};
  end

  // Reference decode straight from the instruction table.
  function automatic out_t model_decode(logic [31:0] inst, logic [31:0] r1, logic [31:0] r2);
    out_t e = '0;
    logic legal = 1'b1;
    int   imm_i = int'($signed(inst[31:20]));
    int   imm_s = int'($signed({inst[31:25], inst[11:7]}));
    e.valid = 1'b1;
    e.rd    = inst[11:7];
    case (inst[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.rw = 1'b1;
        if (inst[31:25] == 7'h00 && inst[14:12] == 3'd0)      e.op = ALU_ADD;
        else if (inst[31:25] == 7'h20 && inst[14:12] == 3'd0) e.op = ALU_SUB;
        else if (inst[31:25] == 7'h00 && inst[14:12] == 3'd7) e.op = ALU_AND;
        else if (inst[31:25] == 7'h00 && inst[14:12] == 3'd6) e.op = ALU_OR;
        else legal = 1'b0;
      end
      7'h13: begin
        e.a = r1; e.b = imm_i; e.rw = 1'b1;
        if (inst[14:12] == 3'd0)      e.op = ALU_ADD;
        else if (inst[14:12] == 3'd7) e.op = ALU_AND;
        else if (inst[14:12] == 3'd6) e.op = ALU_OR;
        else legal = 1'b0;
      end
      7'h03: begin
        e.a = r1; e.b = imm_i; e.mr = 1'b1; e.rw = 1'b1;
        legal = (inst[14:12] == 3'd2);
      end
      7'h23: begin
        e.a = r1; e.b = imm_s; e.sd = r2; e.mw = 1'b1;
        legal = (inst[14:12] == 3'd2);
      end
      7'h63: begin
        e.op = ALU_SUB; e.a = r1; e.b = r2; e.br = 1'b1; e.bne = (inst[14:12] == 3'd1);
        legal = (inst[14:12] <= 3'd1);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0; e.valid = 1'b1; e.rd = inst[11:7]; e.ill = 1'b1;
    end
    if (e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  // Zero out fields the stage leaves unspecified so they never count as differences.
  function automatic out_t masked(out_t o, out_t e, logic known);
    out_t m = o;
    if (!known) begin
      m = '0; m.valid = o.valid;
    end else if (e.ill) begin
      m.a = '0; m.b = '0; m.sd = '0;
    end else if (!e.mw) begin
      m.sd = '0;
    end
    return m;
  endfunction

  // Drives one cycle and advances the reference model across the clock edge.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] inst,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic rdy, input logic fl);
    @(negedge clk_i);
    rst_i = rst; inst_valid_i = v; inst_i = inst; rs1_data_i = r1; rs2_data_i = r2;
    ex_ready_i = rdy; flush_i = fl;
    #1;
    ready_obs = inst_ready_o;
    ready_exp = !fl && (!exp_o.valid || rdy);
    @(posedge clk_i);
    if (rst) begin
      exp_o = '0; exp_known = 1'b1;
    end else if (fl) begin
      exp_o.valid = 1'b0; exp_known = 1'b0;
    end else if (v && ready_exp) begin
      exp_o = model_decode(inst, r1, r2); exp_known = 1'b1;
    end else if (rdy && exp_o.valid) begin
      exp_o.valid = 1'b0; exp_known = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 32'h402081B3, 32'd5, 32'd6, 1, 0);
    cycle(1, 1, 32'h402081B3, 32'd5, 32'd6, 0, 0);
    tests_run++;
    if (obs !== out_t'('0)) begin
      tests_failed++; $display("FAIL reset_state: got %h want 0", obs);
    end
    cycle(0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    tests_run++;
    if (ready_obs !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 1", ready_obs);
    end
  endtask

  task automatic test_rtype_throughput();
    logic [31:0] insts [3] = '{32'h402081B3, 32'h0020F233, 32'h0020E2B3};
    foreach (insts[i]) begin
      cycle(0, 1, insts[i], 32'd10, 32'd3, 1, 0);
      tests_run++;
      if (ready_obs !== 1'b1 || masked(obs, exp_o, exp_known) !== masked(exp_o, exp_o, exp_known)) begin
        tests_failed++;
        $display("FAIL rtype_%0d: got rdy=%b %h want rdy=1 %h", i, ready_obs, obs, exp_o);
      end
      if (i == 0) begin
        tests_run++;
        if (alu_op_o !== ALU_SUB || A_o !== 32'd10 || B_o !== 32'd3 || rd_o !== 5'd3 || reg_write_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL sub_fields: got op=%0d A=%0d B=%0d rd=%0d rw=%b want 1 10 3 3 1",
                   alu_op_o, A_o, B_o, rd_o, reg_write_o);
        end
      end
    end
  endtask

  task automatic test_imm_sext();
    cycle(0, 1, 32'hFFF00293, 32'd0, 32'd0, 1, 0);
    tests_run++;
    if (B_o !== 32'hFFFFFFFF || alu_op_o !== ALU_ADD || reg_write_o !== 1'b1 || ex_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL addi_sext: got B=%h op=%0d rw=%b v=%b want ffffffff 0 1 1", B_o, alu_op_o, reg_write_o, ex_valid_o);
    end
    cycle(0, 1, 32'hFE20AE23, 32'h1000, 32'hCAFEF00D, 1, 0);
    tests_run++;
    if (B_o !== 32'hFFFFFFFC || mem_write_o !== 1'b1 || reg_write_o !== 1'b0 || store_data_o !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL sw_sext: got B=%h mw=%b rw=%b sd=%h want fffffffc 1 0 cafef00d",
               B_o, mem_write_o, reg_write_o, store_data_o);
    end
  endtask

  task automatic test_stall();
    out_t held;
    cycle(0, 1, 32'h0020F233, 32'h11, 32'h22, 1, 0);
    held = obs;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 32'h402081B3, 32'h100 + i, 32'h200 + i, 0, 0);
      tests_run++;
      if (ready_obs !== 1'b0 || obs !== held) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got rdy=%b %h want rdy=0 %h", i, ready_obs, obs, held);
      end
    end
    cycle(0, 1, 32'h402081B3, 32'd50, 32'd8, 1, 0);
    tests_run++;
    if (ready_obs !== 1'b1 || alu_op_o !== ALU_SUB || A_o !== 32'd50 || B_o !== 32'd8 || ex_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: got rdy=%b op=%0d A=%0d B=%0d v=%b want 1 1 50 8 1",
               ready_obs, alu_op_o, A_o, B_o, ex_valid_o);
    end
    cycle(0, 1, 32'h0020E2B3, 32'd1, 32'd2, 0, 0);
    cycle(1, 1, 32'h0020E2B3, 32'd1, 32'd2, 0, 0);
    tests_run++;
    if (ex_valid_o !== 1'b0 || obs !== out_t'('0)) begin
      tests_failed++; $display("FAIL reset_mid_stall: got %h want 0", obs);
    end
  endtask

  task automatic test_flush();
    cycle(0, 1, 32'h0020F233, 32'd7, 32'd9, 0, 0);
    cycle(0, 1, 32'h402081B3, 32'd4, 32'd1, 1, 1);
    tests_run++;
    if (ready_obs !== 1'b0 || ex_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush: got rdy=%b v=%b want 0 0", ready_obs, ex_valid_o);
    end
    cycle(0, 1, 32'h402081B3, 32'd4, 32'd1, 1, 0);
    tests_run++;
    if (ex_valid_o !== 1'b1 || alu_op_o !== ALU_SUB || A_o !== 32'd4) begin
      tests_failed++; $display("FAIL flush_represent: got v=%b op=%0d A=%0d want 1 1 4", ex_valid_o, alu_op_o, A_o);
    end
  endtask

  task automatic test_illegal_x0();
    cycle(0, 1, 32'h000012B7, 32'd3, 32'd4, 1, 0);
    tests_run++;
    if (illegal_o !== 1'b1 || ex_valid_o !== 1'b1 || alu_op_o !== ALU_ADD ||
        {reg_write_o, mem_read_o, mem_write_o, branch_o, branch_ne_o} !== 5'b0) begin
      tests_failed++; $display("FAIL lui_illegal: got %h want ill=1 controls 0", obs);
    end
    cycle(0, 1, 32'h00208033, 32'd3, 32'd4, 1, 0);
    tests_run++;
    if (reg_write_o !== 1'b0 || illegal_o !== 1'b0 || rd_o !== 5'd0) begin
      tests_failed++; $display("FAIL add_x0: got rw=%b ill=%b rd=%0d want 0 0 0", reg_write_o, illegal_o, rd_o);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] inst = $urandom;
      if ($urandom_range(9) < 8) begin
        inst[6:0] = opcs[$urandom_range(5)];
        if ($urandom_range(1)) inst[14:12] = 3'($urandom_range(2)) ^ {1'b0, inst[13], 1'b0} ;
        case ($urandom_range(2))
          0: inst[31:25] = 7'h00;
          1: inst[31:25] = 7'h20;
          default: ;
        endcase
      end
      cycle(($urandom_range(49) == 0), ($urandom_range(3) != 0), inst, $urandom, $urandom,
            ($urandom_range(2) != 0), ($urandom_range(14) == 0));
      tests_run++;
      if (ready_obs !== ready_exp || masked(obs, exp_o, exp_known) !== masked(exp_o, exp_o, exp_known)) begin
        tests_failed++;
        $display("FAIL random_%0d: got rdy=%b %h want rdy=%b %h", n, ready_obs, obs, ready_exp, exp_o);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; inst_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b0;
    inst_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    exp_o = '0; exp_known = 1'b1; ready_obs = 1'b0; ready_exp = 1'b0;
    test_reset();
    test_rtype_throughput();
    test_imm_sext();
    test_stall();
    test_flush();
    test_illegal_x0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
